// File: rtl/fm_modulator.sv
// FM transmitter: base-band samples from a small FIFO modulate a DDS phase accumulator.
// Emits the phase MSB as a 1-bit FM signal, plus the base-band clock and consumption strobe.
module fm_modulator #(
  parameter int unsigned width_dds    = 32,
  parameter int unsigned width_cordic = 17,
  parameter int unsigned width_kdev   = 24,
  parameter int unsigned M            = 240,
  parameter int unsigned FIFO_DEPTH   = 2
) (
  input  logic                           clk_s,
  input  logic                           reset,
  input  logic        [width_dds-1:0]    K,
  input  logic        [width_kdev-1:0]   kdev,
  input  logic signed [width_cordic-1:0] in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic                           clk_b,
  output logic                           strobe,
  output logic        [width_dds-1:0]    phase,
  output logic                           fm_out,
  output logic                           underrun
);

  localparam int unsigned CntW     = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned PtrW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CountW   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ProdW    = width_cordic + width_kdev + 1;
  localparam int unsigned DevShift = 16;

  // Divider state
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            clk_b_q, clk_b_d;
  logic            strobe_q, strobe_d;

  // Sample FIFO state
  logic [width_cordic-1:0] mem_q [FIFO_DEPTH];
  logic [width_cordic-1:0] mem_d [FIFO_DEPTH];
  logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0]       count_q, count_d;
  logic                    full, empty, push, pop;

  // Arithmetic pipeline state
  logic signed [width_cordic-1:0] cur_sample_q, cur_sample_d;
  logic signed [ProdW-1:0]        prod_q, prod_d;
  logic signed [ProdW-1:0]        sample_ext, kdev_ext, prod_sh;
  logic        [width_dds-1:0]    inc_q, inc_d;
  logic        [width_dds-1:0]    phase_q, phase_d;
  logic                           fm_out_q, fm_out_d;
  logic                           underrun_q, underrun_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    cnt_d    = (cnt_q == CntW'(M - 1)) ? '0 : cnt_q + 1'b1;
    clk_b_d  = (cnt_q < CntW'(M / 2));
    strobe_d = (cnt_q == CntW'(M - 1));
  end

  assign full     = (count_q == CountW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = strobe_q && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // On a starved strobe the previous sample keeps modulating the carrier.
  always_comb begin
    cur_sample_d = pop ? $signed(mem_q[rd_ptr_q]) : cur_sample_q;
    underrun_d   = underrun_q | (strobe_q & empty);
  end

  always_comb begin
    sample_ext = ProdW'(cur_sample_q);
    kdev_ext   = ProdW'({1'b0, kdev});
    prod_d     = sample_ext * kdev_ext;
    // Arithmetic shift: rounds toward -inf, so negative deviations are floored.
    prod_sh    = prod_q >>> DevShift;
    inc_d      = K + width_dds'(prod_sh);
    phase_d    = phase_q + inc_q;
    fm_out_d   = phase_d[width_dds-1];
  end

  always_ff @(posedge clk_s) begin
    if (!reset) begin
      cnt_q        <= '0;
      clk_b_q      <= 1'b0;
      strobe_q     <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      cur_sample_q <= '0;
      prod_q       <= '0;
      inc_q        <= '0;
      phase_q      <= '0;
      fm_out_q     <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      clk_b_q      <= clk_b_d;
      strobe_q     <= strobe_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      cur_sample_q <= cur_sample_d;
      prod_q       <= prod_d;
      inc_q        <= inc_d;
      phase_q      <= phase_d;
      fm_out_q     <= fm_out_d;
      underrun_q   <= underrun_d;
    end
  end

  // Storage needs no reset: the occupancy count alone decides what is valid.
  always_ff @(posedge clk_s) begin
    mem_q <= mem_d;
  end

  assign clk_b    = clk_b_q;
  assign strobe   = strobe_q;
  assign phase    = phase_q;
  assign fm_out   = fm_out_q;
  assign underrun = underrun_q;

endmodule

// File: doc/fm_modulator.md
Name: fm_modulator

Overview:
Digital FM transmitter: the counterpart of radio_core's demodulator. It takes signed base-band samples at the base-band rate and frequency-modulates a DDS carrier. It emits a 1-bit square-wave FM signal at the sampling clock, in the same form radio_core expects on its adc input, so the two blocks can be looped back. It also generates the base-band clock clk_b and the sample-consumption strobe from a ratio-M divider.

Parameters:
width_dds, 32, phase accumulator and K width
width_cordic, 17, signed base-band sample width (matches demodulator output)
width_kdev, 24, unsigned deviation gain width
M, 240, clk_s cycles per base-band sample
FIFO_DEPTH, 2, input sample FIFO entries

Ports:
clk_s  input  1  sampling clock (240 MHz nominal); sole clock
reset  input  1  synchronous, active-low reset (reset == 0 resets on clk_s rising edge)
K  input  width_dds  carrier phase increment (2^32*fc/fs)
kdev  input  width_kdev  deviation gain
in_data  input  width_cordic  signed modulating sample
in_valid  input  1  in_data valid
in_ready  output  1  FIFO can accept a sample
clk_b  output  1  base-band clock, period M clk_s cycles
strobe  output  1  one-cycle sample-consumption pulse
phase  output  width_dds  phase accumulator (debug/verification)
fm_out  output  1  1-bit FM signal = phase MSB
underrun  output  1  sticky: strobe occurred with FIFO empty

Behaviour:
- Reset (reset == 0 at a clk_s edge): divider cnt=0; FIFO empty; cur_sample=0; prod_r=0; inc_r=0; phase=0; fm_out=0; clk_b=0; strobe=0; underrun=0. in_ready=1 from the first cycle after reset.
- Reset mid-operation: all state is discarded the same way; queued samples are lost.
- Divider: cnt counts 0..M-1 and wraps to 0.
  - clk_b is registered: 1 when cnt < M/2, else 0.
  - strobe is registered: 1 for exactly one cycle when cnt == M-1, i.e. once every M cycles.
- FIFO: FIFO_DEPTH entries. Push on in_valid && in_ready. in_ready = !full (combinational from count).
  - Pop on strobe when not empty; the head goes to cur_sample on the next edge.
  - Push and pop in the same cycle: count unchanged. When full, in_ready=0, so no simultaneous push is possible.
- Underrun: strobe with FIFO empty → cur_sample holds its last value and underrun is set. underrun is cleared only by reset.
- Arithmetic pipeline (one stage per edge):
  - prod_r = cur_sample * $signed({1'b0,kdev}) (full signed width, width_cordic + width_kdev + 1 bits).
  - inc_r = K + (prod_r >>> 16), truncated modulo 2^width_dds.
  - phase <= phase + inc_r, modulo 2^width_dds; wraps silently.
  - fm_out <= MSB of the new phase value (registered alongside phase).
- Latency: if cur_sample updates at edge n, prod_r updates at n+1, inc_r at n+2, and the first phase step using the new increment occurs at edge n+3.
- K and kdev are sampled every cycle with no holding; a change propagates to the phase step within 2 cycles (kdev) or 1 cycle (K).
- Negative samples lower the instantaneous frequency below the carrier, positive samples raise it. An arithmetic shift rounds toward -inf.

Test Plan:
- Reset/idle: hold reset=0 for 5 cycles, then release → all outputs 0, in_ready=1. First strobe at the cycle where cnt==M-1 (240th cycle after release). clk_b high for 120 cycles and low for 120 cycles.
- Unmodulated carrier: K=32'h6AAA_AAAB, kdev=0 → phase increases by exactly 0x6AAAAAAB per cycle after 2-cycle fill. fm_out toggles with a mean of 2.4 clk_s cycles per period (100 MHz). No underrun while samples are supplied continuously.
- Deviation: kdev=1342197, push in_data=+65535 → after pop plus 3 cycles, phase step = K + 1342176 (+75 kHz). With in_data=-65536 the step is K - 1342197.
- Backpressure: hold in_valid=1 with incrementing data → in_ready drops after 2 accepted samples. Thereafter exactly one sample is accepted per strobe, in order, with no loss or duplication (verify via phase steps).
- Underrun: push one sample (+1000), then stop → the next strobe sets underrun=1 and the increment keeps using +1000. Pushing again does not clear underrun; only reset does.
- Loopback: drive fm_out into radio_core's adc, sharing clk_s and clk_b and using the same K. Send a 1 kHz sine of amplitude 32768 → demodulated output is a 1 kHz sine. Correlate against the input after the pipeline delays.
